// File: rtl/btn_msg_sender_if.sv
// Byte valid/ready handshake between the message sender and the UART transmitter.
interface btn_msg_sender_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/btn_msg_sender.sv
// Streams a fixed ASCII message to the UART on each button request, buffering one extra request.
// Optional CR/LF terminator enabled by defining BTN_MSG_CRLF_EN.
module btn_msg_sender #(
  parameter int unsigned          MSG_LEN = 5,
  parameter logic [8*MSG_LEN-1:0] MSG     = "HELLO",
  parameter int unsigned          IDX_W   = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    trig_pulse,
  btn_msg_sender_if.master        tx,
  output logic                    busy,
  output logic                    done_pulse,
  output logic [7:0]              req_count,
  output logic                    drop_flag
);

`ifdef BTN_MSG_CRLF_EN
  localparam int unsigned NumBytes = MSG_LEN + 2;
`else
  localparam int unsigned NumBytes = MSG_LEN;
`endif
  localparam logic [IDX_W-1:0] Last = IDX_W'(NumBytes - 1);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  function automatic logic [7:0] msg_byte(logic [IDX_W-1:0] idx);
    logic [8*MSG_LEN-1:0] sh;
    sh       = MSG << {idx, 3'b000};
    msg_byte = sh[8*MSG_LEN-1 -: 8];
`ifdef BTN_MSG_CRLF_EN
    if (idx == IDX_W'(MSG_LEN)) begin
      msg_byte = 8'h0D;
    end else if (idx == IDX_W'(MSG_LEN + 1)) begin
      msg_byte = 8'h0A;
    end
`endif
  endfunction

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pending_q, pending_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic [7:0]       count_q, count_d;
  logic             drop_q, drop_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    data_d    = data_q;
    valid_d   = valid_q;
    count_d   = count_q;
    drop_d    = drop_q;
    unique case (state_q)
      StIdle: begin
        if (trig_pulse) begin
          state_d = StSend;
          idx_d   = '0;
          data_d  = msg_byte('0);
          valid_d = 1'b1;
          count_d = count_q + 8'd1;
        end
      end
      StSend: begin
        if (trig_pulse) begin
          if (pending_q) begin
            drop_d = 1'b1;
          end else begin
            pending_d = 1'b1;
          end
        end
        if (valid_q && tx.tx_ready) begin
          if (idx_q == Last) begin
            valid_d = 1'b0;
            state_d = StDone;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            data_d = msg_byte(idx_q + IDX_W'(1));
          end
        end
      end
      StDone: begin
        // A trigger landing here is buffered and consumed at once; if a request was already
        // pending, the pending one starts and the new trigger becomes the next pending request.
        if (pending_q || trig_pulse) begin
          state_d   = StSend;
          idx_d     = '0;
          data_d    = msg_byte('0);
          valid_d   = 1'b1;
          count_d   = count_q + 8'd1;
          pending_d = pending_q && trig_pulse;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      pending_q <= 1'b0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      count_q   <= 8'd0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
      drop_q    <= drop_d;
    end
  end

  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;
  assign busy        = (state_q != StIdle);
  assign done_pulse  = (state_q == StDone);
  assign req_count   = count_q;
  assign drop_flag   = drop_q;

endmodule

// File: tb/tb_btn_msg_sender.sv
// Self-checking bench for btn_msg_sender: reset/latency table, directed corner sequences and
// randomized traffic compared against a remaining-bytes request model.
module tb_btn_msg_sender;

`ifdef BTN_MSG_CRLF_EN
  localparam int NB = 7;
`else
  localparam int NB = 5;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trig_pulse;
  logic       busy;
  logic       done_pulse;
  logic [7:0] req_count;
  logic       drop_flag;

  always #5 clk = ~clk;

  btn_msg_sender_if bus ();

  btn_msg_sender dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trig_pulse (trig_pulse),
    .tx         (bus),
    .busy       (busy),
    .done_pulse (done_pulse),
    .req_count  (req_count),
    .drop_flag  (drop_flag)
  );

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;

  // Request-level model: bytes still to send, one DONE cycle, one queued request.
  int m_rem;
  bit m_done;
  bit m_queued;
  bit m_drop;
  int m_cnt;

  function automatic logic [7:0] exp_byte(int i);
    case (i)
      0:       exp_byte = 8'h48;
      1:       exp_byte = 8'h45;
      2, 3:    exp_byte = 8'h4C;
      4:       exp_byte = 8'h4F;
      5:       exp_byte = 8'h0D;
      6:       exp_byte = 8'h0A;
      default: exp_byte = 8'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_start();
    m_rem = NB;
    m_cnt = (m_cnt + 1) % 256;
  endtask

  task automatic model_step(input bit trig, input bit ready, input bit rst);
    if (!rst) begin
      m_rem = 0; m_done = 0; m_queued = 0; m_drop = 0; m_cnt = 0;
    end else if (m_done) begin
      m_done = 0;
      if (m_queued) begin
        model_start();
        m_queued = trig;
      end else if (trig) begin
        model_start();
      end
    end else if (m_rem > 0) begin
      if (trig) begin
        if (m_queued) m_drop = 1;
        else          m_queued = 1;
      end
      if (ready) begin
        m_rem--;
        if (m_rem == 0) m_done = 1;
      end
    end else if (trig) begin
      model_start();
    end
  endtask

  task automatic compare_model();
    check("tx_valid", {31'b0, bus.tx_valid}, {31'b0, m_rem > 0});
    if (m_rem > 0) check("tx_data", {24'b0, bus.tx_data}, {24'b0, exp_byte(NB - m_rem)});
    check("busy", {31'b0, busy}, {31'b0, (m_rem > 0) || m_done});
    check("done_pulse", {31'b0, done_pulse}, {31'b0, m_done});
    check("req_count", {24'b0, req_count}, m_cnt);
    check("drop_flag", {31'b0, drop_flag}, {31'b0, m_drop});
  endtask

  // Drive away from the edge, advance the model, step one clock and compare.
  task automatic cycle(input bit trig, input bit ready, input bit rst);
    trig_pulse   = trig;
    bus.tx_ready = ready;
    rst_n        = rst;
    if (rst && bus.tx_valid && ready) xfers++;
    model_step(trig, ready, rst);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0);
    check("rst_data", {24'b0, bus.tx_data}, 32'h0);
    xfers = 0;
  endtask

  typedef struct {
    bit         trig;
    bit         ready;
    bit         e_valid;
    logic [7:0] e_data;
    bit         e_busy;
    bit         e_done;
    logic [7:0] e_cnt;
  } vec_t;

  localparam int TblN = NB + 2;
  vec_t tbl [TblN];

  initial begin
    rst_n        = 1'b0;
    trig_pulse   = 1'b0;
    bus.tx_ready = 1'b0;
    m_rem = 0; m_done = 0; m_queued = 0; m_drop = 0; m_cnt = 0;

    tbl[0] = '{1, 1, 1, 8'h48, 1, 0, 8'd1};
    tbl[1] = '{0, 1, 1, 8'h45, 1, 0, 8'd1};
    tbl[2] = '{0, 1, 1, 8'h4C, 1, 0, 8'd1};
    tbl[3] = '{0, 1, 1, 8'h4C, 1, 0, 8'd1};
    tbl[4] = '{0, 1, 1, 8'h4F, 1, 0, 8'd1};
`ifdef BTN_MSG_CRLF_EN
    tbl[5] = '{0, 1, 1, 8'h0D, 1, 0, 8'd1};
    tbl[6] = '{0, 1, 1, 8'h0A, 1, 0, 8'd1};
`endif
    tbl[NB]     = '{0, 1, 0, 8'h00, 1, 1, 8'd1};
    tbl[NB + 1] = '{0, 1, 0, 8'h00, 0, 0, 8'd1};

    repeat (2) @(posedge clk);
    #1;

    // Single request latency and byte order.
    do_reset();
    for (int i = 0; i < TblN; i++) begin
      trig_pulse   = tbl[i].trig;
      bus.tx_ready = tbl[i].ready;
      rst_n        = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_valid", i), {31'b0, bus.tx_valid}, {31'b0, tbl[i].e_valid});
      if (tbl[i].e_valid)
        check($sformatf("tbl%0d_data", i), {24'b0, bus.tx_data}, {24'b0, tbl[i].e_data});
      check($sformatf("tbl%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].e_busy});
      check($sformatf("tbl%0d_done", i), {31'b0, done_pulse}, {31'b0, tbl[i].e_done});
      check($sformatf("tbl%0d_cnt", i), {24'b0, req_count}, {24'b0, tbl[i].e_cnt});
    end

    // Backpressure with a 1-0-0-1 ready pattern.
    do_reset();
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4 * NB + 4; i++) cycle(1'b0, (i % 4 == 0) || (i % 4 == 3), 1'b1);
    check("bp_xfers", xfers, NB);

    // One queued request restarts without an idle cycle.
    do_reset();
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2 * NB + 4; i++) cycle(1'b0, 1'b1, 1'b1);
    check("q_cnt", {24'b0, req_count}, 32'd2);
    check("q_drop", {31'b0, drop_flag}, 32'd0);
    check("q_xfers", xfers, 2 * NB);

    // Three extra triggers during one message: one queued, two dropped.
    do_reset();
    cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2 * NB + 4; i++) cycle(1'b0, 1'b1, 1'b1);
    check("ov_cnt", {24'b0, req_count}, 32'd2);
    check("ov_drop", {31'b0, drop_flag}, 32'd1);
    check("ov_xfers", xfers, 2 * NB);

    // Reset in the middle of a message aborts it.
    do_reset();
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    check("mr_valid", {31'b0, bus.tx_valid}, 32'd0);
    check("mr_busy", {31'b0, busy}, 32'd0);
    check("mr_cnt", {24'b0, req_count}, 32'd0);
    cycle(1'b1, 1'b1, 1'b1);
    check("mr_first", {24'b0, bus.tx_data}, 32'h48);
    for (int i = 0; i < NB + 2; i++) cycle(1'b0, 1'b1, 1'b1);

    // req_count wraps after 256 accepted requests.
    do_reset();
    for (int n = 0; n < 256; n++) begin
      cycle(1'b1, 1'b1, 1'b1);
      repeat (NB + 1) cycle(1'b0, 1'b1, 1'b1);
    end
    check("wrap_cnt", {24'b0, req_count}, 32'd0);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(5) == 0, $urandom_range(9) < 7, $urandom_range(299) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_msg_sender.md
Name: btn_msg_sender

Overview:
- Consumes the one-cycle button pulse from the debounce stage.
- Streams a fixed, parameter-defined ASCII message byte-by-byte into the UART transmitter over a valid/ready byte handshake.
- Buffers at most one extra request that arrives while a message is in flight.
- Reports busy, completion and an accepted-request count for status LEDs.

Parameters:
- MSG_LEN, 5, number of message bytes (1..32).
- MSG, "HELLO" (8*MSG_LEN bits), packed message; byte 0 = MSG[8*MSG_LEN-1 -: 8], sent first.
- IDX_W, 6, width of byte index; must satisfy 2^IDX_W > MSG_LEN+2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- trig_pulse  in  1  single-cycle request from the debounce stage.
- tx_data  out  8  byte offered to the UART transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts; transfer occurs when tx_valid&tx_ready at posedge.
- busy  out  1  high in any state other than IDLE.
- done_pulse  out  1  one cycle after last byte transfers.
- req_count  out  8  accepted requests, wraps 255->0.
- drop_flag  out  1  sticky; set when a request is discarded.

Behaviour:
- Reset is sampled only on a posedge clk with rst_n=0. On reset:
  - FSM goes to IDLE; index=0; pending=0.
  - tx_valid=0, tx_data=0x00, busy=0, done_pulse=0, req_count=0, drop_flag=0.
  - Reset mid-message aborts immediately; no further bytes are sent.
- States: IDLE, SEND, DONE.
- IDLE:
  - trig_pulse=1: load index=0, go to SEND, increment req_count.
  - tx_valid rises on the next cycle, so latency is trigger cycle +1.
- SEND:
  - tx_valid=1; tx_data=byte[index], registered.
  - On a handshake with index<LAST: index+1; the next byte is presented the following cycle with tx_valid held high. Back-to-back bytes are allowed when tx_ready stays high.
  - On a handshake with index==LAST: tx_valid=0 next cycle; go to DONE.
  - tx_data and tx_valid must stay stable while tx_valid=1 and tx_ready=0.
  - LAST = MSG_LEN-1, or MSG_LEN+1 with CRLF enabled.
- DONE (one cycle):
  - done_pulse=1.
  - If pending=1: clear pending, index=0, increment req_count, go to SEND.
  - Otherwise go to IDLE.
- Request buffering:
  - trig_pulse while in SEND or DONE with pending=0 sets pending.
  - trig_pulse with pending already 1 is dropped and sets drop_flag; req_count is unchanged.
  - trig_pulse in the same cycle DONE consumes pending counts as the new pending request, not dropped.
- busy=1 in SEND and DONE.
- drop_flag clears only on reset.
- tx_ready is ignored when tx_valid=0.

Optional Feature:
- Macro: BTN_MSG_CRLF_EN.
- Defined: after the MSG bytes, send 0x0D then 0x0A; total bytes = MSG_LEN+2; done_pulse follows the 0x0A transfer.
- Undefined: exactly MSG_LEN bytes are sent; no terminator logic is present.

Test Plan:
- Single request, tx_ready always 1, MSG="HELLO", CRLF off: trig at cycle 0 -> tx_valid high cycles 1..5 with bytes 0x48,0x45,0x4C,0x4C,0x4F; done_pulse at cycle 6; req_count=1; busy low at cycle 7.
- Backpressure: tx_ready toggles 1-0-0-1 pattern -> each byte held stable while stalled; order unchanged; exactly 5 transfers.
- Queued request: second trig during byte 2 -> after done_pulse, message restarts from 0x48 with no IDLE cycle; req_count=2; drop_flag=0.
- Overflow: three trigs during one message -> two messages sent, req_count=2, drop_flag=1.
- Reset mid-message: rst_n low during byte 3 -> next cycle tx_valid=0, busy=0, req_count=0; a following trig sends the message from byte 0.
- BTN_MSG_CRLF_EN defined: single trig -> 7 transfers ending 0x0D,0x0A; done_pulse after the 0x0A transfer.
